// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_ctrl
// Purpose  : Time-multiplexed scan controller for a common-anode multi-digit
//            seven-segment display. It keeps a double-buffered hex frame and
//            scans one digit at a time. Each digit slot is a blanking interval
//            with all anodes off, followed by a display interval. The selected
//            nibble goes to an external hex-to-7-segment decoder.
//
// Ports    : clk        - system clock
//            rst        - synchronous active-high reset
//            wr_en      - frame write request
//            wr_data    - frame nibbles, [3:0] = digit 0 (rightmost)
//            wr_dp      - decimal-point enables, 1 = lit
//            wr_ready   - pending buffer empty, a write can be taken
//            digit_val  - nibble for the external decoder
//            an_out     - anode selects, active-low
//            dp_out     - decimal point, active-low
//            frame_done - one-cycle pulse on the last cycle of a full scan
//
// Options  : LEADING_ZERO_BLANK_EN - when defined, leading-zero digits are
//            kept dark in their display slot. Digit 0 and digits with their
//            decimal point set are always shown.
//
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SHOW_CYC   = 100000,
    parameter int BLANK_CYC  = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    output logic                    wr_ready,
    output logic [3:0]              digit_val,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    dp_out,
    output logic                    frame_done
);

    localparam int c_cnt_max = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_idx_w   = $clog2(NUM_DIGITS);

    localparam logic [c_cnt_w-1:0] c_show_last  = c_cnt_w'(SHOW_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYC - 1);
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [c_cnt_w-1:0]        w_cnt_next;
    logic [c_idx_w-1:0]        r_idx;
    logic [c_idx_w-1:0]        w_idx_next;
    logic [c_idx_w-1:0]        w_idx_inc;
    logic [3:0]                r_digit_val;
    logic [3:0]                w_digit_next;
    logic                      w_frame_done;

    logic [4*NUM_DIGITS-1:0]   r_active;
    logic [NUM_DIGITS-1:0]     r_active_dp;
    logic [4*NUM_DIGITS-1:0]   r_pend;
    logic [NUM_DIGITS-1:0]     r_pend_dp;
    logic                      r_pend_valid;
    logic                      w_accept;
    logic                      w_commit;
    logic [NUM_DIGITS-1:0]     w_lz_mask;

    assign w_idx_inc = r_idx + 1'b1;

    // A write is only taken while the pending buffer is empty; the commit
    // happens on the last cycle of a scan so a frame never tears mid-scan.
    assign w_accept = wr_en & ~r_pend_valid;
    assign w_commit = w_frame_done & r_pend_valid;

    // ------------------------------------------------------------------------
    // Scan state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_BLANK;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_digit_val <= 4'h0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_digit_val <= w_digit_next;
        end
    end

    // ------------------------------------------------------------------------
    // Scan next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_idx_next   = r_idx;
        w_digit_next = r_digit_val;
        w_frame_done = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == c_blank_last) begin
                    w_state_next = ST_SHOW;
                    w_cnt_next   = '0;
                end
            end
            ST_SHOW: begin
                if (r_cnt == c_show_last) begin
                    w_state_next = ST_BLANK;
                    w_cnt_next   = '0;
                    // digit_val is loaded as BLANK is entered so the external
                    // decoder has the whole blanking interval to settle.
                    if (r_idx == c_idx_last) begin
                        w_idx_next   = '0;
                        w_frame_done = 1'b1;
                        // Digit 0 of the next scan comes from the frame that
                        // is being committed on this very cycle, if any.
                        w_digit_next = r_pend_valid ? r_pend[3:0] : r_active[3:0];
                    end else begin
                        w_idx_next   = w_idx_inc;
                        w_digit_next = r_active[w_idx_inc*4 +: 4];
                    end
                end
            end
            default: begin
                w_state_next = ST_BLANK;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame buffers: pending (written) and active (displayed)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active     <= '0;
            r_active_dp  <= '0;
            r_pend       <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_commit) begin
            r_active     <= r_pend;
            r_active_dp  <= r_pend_dp;
            r_pend_valid <= 1'b0;
        end else if (w_accept) begin
            r_pend       <= wr_data;
            r_pend_dp    <= wr_dp;
            r_pend_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Leading-zero suppression mask, captured at each commit
    // ------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] r_lz_mask;
    logic [NUM_DIGITS-1:0] w_lz_calc;
    logic                  w_seen_nz;

    // Walk from the most significant digit down; every digit above the
    // first nonzero nibble is suppressed unless its decimal point is lit.
    always_comb begin
        w_lz_calc = '0;
        w_seen_nz = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_seen_nz = w_seen_nz | (r_pend[k*4 +: 4] != 4'h0);
            if (k != 0) begin
                w_lz_calc[k] = ~w_seen_nz & ~r_pend_dp[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lz_mask <= '0;
        end else if (w_commit) begin
            r_lz_mask <= w_lz_calc;
        end
    end

    assign w_lz_mask = r_lz_mask;
`else
    assign w_lz_mask = '0;
`endif

    // ------------------------------------------------------------------------
    // Display outputs, decoded from registered state: at most one anode low.
    // ------------------------------------------------------------------------
    always_comb begin
        an_out = '1;
        dp_out = 1'b1;
        if (r_state == ST_SHOW) begin
            an_out[r_idx] = w_lz_mask[r_idx];
            dp_out        = ~r_active_dp[r_idx];
        end
    end

    assign wr_ready   = ~r_pend_valid;
    assign digit_val  = r_digit_val;
    assign frame_done = w_frame_done;

endmodule
`default_nettype wire
